// File: rtl/branch_predictor_if.sv
// Predict/update/statistics bundle between the fetch/execute pipeline and the branch predictor.
// The pipeline side uses the master modport and the predictor uses the slave modport.
interface branch_predictor_if #(
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 16
);
    logic                  if_valid;
    logic [31:0]           if_pc;
    logic                  pred_valid;
    logic                  pred_taken;
    logic [INDEX_BITS-1:0] pred_ghr;
    logic                  upd_valid;
    logic [31:0]           upd_pc;
    logic                  upd_taken;
    logic                  upd_pred_taken;
    logic [INDEX_BITS-1:0] upd_ghr;
    logic                  mispredict;
    logic [CNT_WIDTH-1:0]  branch_cnt;
    logic [CNT_WIDTH-1:0]  mispredict_cnt;

    modport master (
        output if_valid, if_pc,
        output upd_valid, upd_pc, upd_taken, upd_pred_taken, upd_ghr,
        input  pred_valid, pred_taken, pred_ghr,
        input  mispredict, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  if_valid, if_pc,
        input  upd_valid, upd_pc, upd_taken, upd_pred_taken, upd_ghr,
        output pred_valid, pred_taken, pred_ghr,
        output mispredict, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped table of 2-bit saturating counters with misprediction pulse and saturating statistics.
// Define GSHARE_EN to XOR a non-speculative global history register into the table index.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 16
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            table_q [ENTRIES];
    logic [ENTRIES-1:0]    entry_we;
    logic [INDEX_BITS-1:0] ridx;
    logic [INDEX_BITS-1:0] widx;
    logic [INDEX_BITS-1:0] lookup_ghr;
    logic [1:0]            upd_entry;
    logic [1:0]            upd_entry_d;

    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_ghr_q, pred_ghr_d;
    logic                  mispredict_q, mispredict_d;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  mispredict_cnt_q, mispredict_cnt_d;
    logic                  mis_event;

`ifdef GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q, ghr_d;

    // History is shifted only at resolve time, so a same-cycle lookup still sees the old value.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.upd_valid) begin
            ghr_d = {ghr_q[INDEX_BITS-2:0], bp.upd_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign lookup_ghr = ghr_q;
    assign widx       = bp.upd_pc[INDEX_BITS+1:2] ^ bp.upd_ghr;
`else
    logic unused_upd_ghr;
    assign unused_upd_ghr = ^bp.upd_ghr;
    assign lookup_ghr     = '0;
    assign widx           = bp.upd_pc[INDEX_BITS+1:2];
`endif

    assign ridx = bp.if_pc[INDEX_BITS+1:2] ^ lookup_ghr;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.if_pc[31:INDEX_BITS+2], bp.if_pc[1:0],
                              bp.upd_pc[31:INDEX_BITS+2], bp.upd_pc[1:0]};

    assign upd_entry = table_q[widx];
    always_comb begin
        upd_entry_d = upd_entry;
        if (bp.upd_taken) begin
            if (upd_entry != 2'b11) upd_entry_d = upd_entry + 2'b01;
        end else begin
            if (upd_entry != 2'b00) upd_entry_d = upd_entry - 2'b01;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry_we
            assign entry_we[gi] = bp.upd_valid && (widx == INDEX_BITS'(gi));
        end
    endgenerate

    // Reset reinitialises every entry at once, so an in-flight update is simply lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (entry_we[i]) table_q[i] <= upd_entry_d;
            end
        end
    end

    // The lookup samples table_q before this edge's write lands, giving read-before-write on collisions.
    always_comb begin
        pred_valid_d     = bp.if_valid;
        pred_taken_d     = pred_taken_q;
        pred_ghr_d       = pred_ghr_q;
        if (bp.if_valid) begin
            pred_taken_d = table_q[ridx][1];
            pred_ghr_d   = lookup_ghr;
        end
        mis_event        = bp.upd_valid && (bp.upd_taken != bp.upd_pred_taken);
        mispredict_d     = mis_event;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (bp.upd_valid && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        end
        if (mis_event && (mispredict_cnt_q != '1)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q     <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_ghr_q       <= '0;
            mispredict_q     <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            pred_valid_q     <= pred_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_ghr_q       <= pred_ghr_d;
            mispredict_q     <= mispredict_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bp.pred_valid     = pred_valid_q;
    assign bp.pred_taken     = pred_taken_q;
    assign bp.pred_ghr       = pred_ghr_q;
    assign bp.mispredict     = mispredict_q;
    assign bp.branch_cnt     = branch_cnt_q;
    assign bp.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed predict/update vectors push expectations,
// a negedge monitor pops and compares them. Statistics counters are narrowed to 4 bits.
module tb_branch_predictor;
    localparam int IB = 6;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.INDEX_BITS(IB), .CNT_WIDTH(CW)) bus ();

    branch_predictor #(.INDEX_BITS(IB), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus)
    );

    typedef struct {
        logic          taken;
        logic [IB-1:0] ghr;
        string         tag;
    } pred_exp_t;

    typedef struct {
        logic          mis;
        logic [CW-1:0] bcnt;
        logic [CW-1:0] mcnt;
        string         tag;
    } upd_exp_t;

    pred_exp_t pq[$];
    upd_exp_t  uq[$];
    int checks = 0;
    int errors = 0;
    logic saw_pred = 1'b0;
    logic saw_upd  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic set_pred(input logic [31:0] pc, input logic exp_taken,
                            input logic [IB-1:0] exp_ghr, input string tag);
        pred_exp_t e;
        bus.if_valid = 1'b1;
        bus.if_pc    = pc;
        e.taken = exp_taken;
        e.ghr   = exp_ghr;
        e.tag   = tag;
        pq.push_back(e);
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic taken, input logic predt,
                           input logic [IB-1:0] ghr, input logic exp_mis,
                           input int exp_b, input int exp_m, input string tag);
        upd_exp_t e;
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_taken      = taken;
        bus.upd_pred_taken = predt;
        bus.upd_ghr        = ghr;
        e.mis  = exp_mis;
        e.bcnt = CW'(exp_b);
        e.mcnt = CW'(exp_m);
        e.tag  = tag;
        uq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.if_valid  = 1'b0;
        bus.upd_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_pred_valid"}, 32'(bus.pred_valid), 32'd0);
        chk({pfx, "_pred_taken"}, 32'(bus.pred_taken), 32'd0);
        chk({pfx, "_pred_ghr"}, 32'(bus.pred_ghr), 32'd0);
        chk({pfx, "_mispredict"}, 32'(bus.mispredict), 32'd0);
        chk({pfx, "_branch_cnt"}, 32'(bus.branch_cnt), 32'd0);
        chk({pfx, "_mispredict_cnt"}, 32'(bus.mispredict_cnt), 32'd0);
    endtask

    // Record which transactions the DUT accepted on this edge.
    always @(posedge clk) begin
        if (rst) begin
            saw_pred <= 1'b0;
            saw_upd  <= 1'b0;
        end else begin
            saw_pred <= bus.if_valid;
            saw_upd  <= bus.upd_valid;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (saw_pred) begin
                if (pq.size() == 0) begin
                    chk("pred_queue_empty", 32'd1, 32'd0);
                end else begin
                    pred_exp_t e;
                    e = pq.pop_front();
                    chk({e.tag, "_valid"}, 32'(bus.pred_valid), 32'd1);
                    chk({e.tag, "_taken"}, 32'(bus.pred_taken), 32'(e.taken));
                    chk({e.tag, "_ghr"}, 32'(bus.pred_ghr), 32'(e.ghr));
                end
            end else begin
                chk("pred_idle_valid", 32'(bus.pred_valid), 32'd0);
            end
            if (saw_upd) begin
                if (uq.size() == 0) begin
                    chk("upd_queue_empty", 32'd1, 32'd0);
                end else begin
                    upd_exp_t u;
                    u = uq.pop_front();
                    chk({u.tag, "_mispredict"}, 32'(bus.mispredict), 32'(u.mis));
                    chk({u.tag, "_branch_cnt"}, 32'(bus.branch_cnt), 32'(u.bcnt));
                    chk({u.tag, "_mispredict_cnt"}, 32'(bus.mispredict_cnt), 32'(u.mcnt));
                end
            end else begin
                chk("upd_idle_mispredict", 32'(bus.mispredict), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.if_valid       = 1'b0;
        bus.if_pc          = '0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = '0;
        bus.upd_taken      = 1'b0;
        bus.upd_pred_taken = 1'b0;
        bus.upd_ghr        = '0;
        rst                = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

`ifdef GSHARE_EN
        // Train entry 6 to strong-taken, leaving GHR = 000110.
        set_upd(32'h18, 1'b1, 1'b1, 6'd0, 1'b0, 1, 0, "g_up1"); tick();
        set_upd(32'h18, 1'b1, 1'b1, 6'd0, 1'b0, 2, 0, "g_up2"); tick();
        set_upd(32'h00, 1'b0, 1'b0, 6'd0, 1'b0, 3, 0, "g_up3"); tick();
        set_pred(32'h100, 1'b1, 6'h06, "g_pred_ghr06"); tick();
        // Same-cycle predict and update: lookup still uses GHR 06; GHR becomes 0D.
        set_pred(32'h100, 1'b1, 6'h06, "g_pred_old_ghr");
        set_upd(32'h00, 1'b1, 1'b1, 6'd0, 1'b0, 4, 0, "g_up4"); tick();
        set_pred(32'h100, 1'b0, 6'h0D, "g_pred_ghr0d"); tick();
        // Write index 1^12 = 13 (entry -> 10); GHR becomes 1B; pc 0x58 reads 22^27 = 13.
        set_upd(32'h04, 1'b1, 1'b1, 6'd12, 1'b0, 5, 0, "g_up_widx"); tick();
        set_pred(32'h58, 1'b1, 6'h1B, "g_pred_widx"); tick();
`else
        set_pred(32'h100, 1'b0, 6'd0, "t1_pred"); tick();
        tick();
        set_upd(32'h104, 1'b1, 1'b0, 6'd0, 1'b1, 1, 1, "t3_mis"); tick();
        tick();
        set_upd(32'h104, 1'b1, 1'b1, 6'd0, 1'b0, 2, 1, "t3_match"); tick();
        set_upd(32'h100, 1'b1, 1'b0, 6'd0, 1'b1, 3, 2, "t2_up01_10"); tick();
        set_upd(32'h100, 1'b1, 1'b1, 6'd0, 1'b0, 4, 2, "t2_up10_11"); tick();
        set_pred(32'h100, 1'b1, 6'd0, "t2_pred11"); tick();
        set_upd(32'h100, 1'b1, 1'b1, 6'd0, 1'b0, 5, 2, "t2_sat11"); tick();
        set_upd(32'h100, 1'b0, 1'b1, 6'd0, 1'b1, 6, 3, "t2_dn11_10"); tick();
        set_pred(32'h100, 1'b1, 6'd0, "t2_pred10"); tick();
        set_upd(32'h100, 1'b0, 1'b1, 6'd0, 1'b1, 7, 4, "t2_dn10_01"); tick();
        set_pred(32'h100, 1'b0, 6'd0, "t2_pred01"); tick();
        set_upd(32'h100, 1'b0, 1'b0, 6'd0, 1'b0, 8, 4, "t2_dn01_00"); tick();
        set_upd(32'h100, 1'b0, 1'b0, 6'd0, 1'b0, 9, 4, "t2_sat00"); tick();
        set_upd(32'h100, 1'b1, 1'b0, 6'd0, 1'b1, 10, 5, "t2_up00_01"); tick();
        set_pred(32'h100, 1'b0, 6'd0, "t2_pred_after_sat00"); tick();
        // Collision: read-before-write on entry 0.
        set_pred(32'h200, 1'b0, 6'd0, "t4_collide_pred");
        set_upd(32'h200, 1'b1, 1'b0, 6'd0, 1'b1, 11, 6, "t4_collide_upd"); tick();
        set_pred(32'h200, 1'b1, 6'd0, "t4_pred_after"); tick();
        set_pred(32'h108, 1'b0, 6'd0, "t4_untouched"); tick();
        set_pred(32'h104, 1'b1, 6'd0, "t4_entry1"); tick();
        set_pred(32'h300, 1'b1, 6'd0, "t4_alias300"); tick();
        set_pred(32'h303, 1'b1, 6'd0, "t4_alias303_lowbits"); tick();
        for (int i = 0; i < 20; i++) begin
            int b;
            int m;
            b = (12 + i > 15) ? 15 : 12 + i;
            m = (7 + i > 15) ? 15 : 7 + i;
            set_upd(32'h400, 1'b1, 1'b0, 6'd0, 1'b1, b, m, $sformatf("t5_sat%0d", i));
            tick();
        end
`endif
        tick();
        // Reset asserted mid-cycle while an update is presented: outputs clear immediately.
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = 32'h400;
        bus.upd_taken      = 1'b1;
        bus.upd_pred_taken = 1'b0;
        bus.upd_ghr        = '0;
        bus.if_valid       = 1'b1;
        bus.if_pc          = 32'h400;
        #6;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        bus.if_valid  = 1'b0;
        bus.upd_valid = 1'b0;
        pq.delete();
        uq.delete();
        rst = 1'b0;
        set_pred(32'h400, 1'b0, 6'd0, "t5_table_reset"); tick();
        set_upd(32'h104, 1'b0, 1'b0, 6'd0, 1'b0, 1, 0, "t5_cnt_restart"); tick();
        set_pred(32'h104, 1'b0, 6'd0, "t5_entry1_00"); tick();
        repeat (3) tick();
        chk("pred_queue_drained", 32'(pq.size()), 32'd0);
        chk("upd_queue_drained", 32'(uq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to branch resolution: predicts conditional-branch direction before the ALU evaluates it.
- Learns from the resolved outcome, i.e. the branch_estab result fed back from execute.
- Sits beside the IF-stage PC register: the predict port is read in IF, the update port is written from EX.
- Direct-mapped table of 2-bit saturating counters, plus misprediction flag and statistics counters.

Parameters:
INDEX_BITS, 6, log2 of pattern-table entries (64 entries); table index = PC[INDEX_BITS+1:2]
CNT_WIDTH, 16, width of the branch and mispredict statistics counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
if_valid  input  1  fetch PC is valid this cycle
if_pc  input  32  fetch PC to predict
pred_valid  output  1  registered; prediction valid, one cycle after if_valid
pred_taken  output  1  registered; predicted direction (counter MSB)
pred_ghr  output  INDEX_BITS  registered; history snapshot used for the prediction (0 when GSHARE_EN is undefined)
upd_valid  input  1  resolved conditional branch this cycle
upd_pc  input  32  PC of the resolved branch
upd_taken  input  1  actual outcome (branch_estab)
upd_pred_taken  input  1  direction that was predicted for this branch
upd_ghr  input  INDEX_BITS  history snapshot returned with the branch (ignored when GSHARE_EN is undefined)
mispredict  output  1  registered; pulses 1 cycle after upd_valid when upd_taken != upd_pred_taken
branch_cnt  output  CNT_WIDTH  number of upd_valid events, saturating
mispredict_cnt  output  CNT_WIDTH  number of mispredictions, saturating

Behaviour:
- Reset (async, rst=1): every table entry = 2'b01 (weakly not-taken). pred_valid=0, pred_taken=0, pred_ghr=0, mispredict=0, branch_cnt=0, mispredict_cnt=0, GHR=0. Reset mid-update discards the update; no partial writes.
- Predict, 1-cycle latency: on the clk edge with if_valid=1:
  - pred_valid<=1.
  - pred_taken<=table[ridx][1].
  - pred_ghr<=GHR (0 without GSHARE_EN).
- Predict with if_valid=0: pred_valid<=0; pred_taken and pred_ghr hold their values.
- Update: on the clk edge with upd_valid=1, entry table[widx]:
  - upd_taken=1: increment, saturating at 2'b11.
  - upd_taken=0: decrement, saturating at 2'b00.
  - Saturation boundaries: 11 + taken stays 11; 00 + not-taken stays 00.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predicted taken iff MSB=1.
- Same-entry collision (ridx==widx in the same cycle): the prediction uses the pre-update value (read-before-write). The new value is visible from the next cycle.
- mispredict<=upd_valid & (upd_taken ^ upd_pred_taken); otherwise 0. It is a single-cycle pulse per event.
- Statistics:
  - branch_cnt increments on each upd_valid.
  - mispredict_cnt increments on each mispredict event.
  - Both hold at all-ones (2^CNT_WIDTH-1) and never wrap.
- Index without GSHARE_EN: ridx=if_pc[INDEX_BITS+1:2], widx=upd_pc[INDEX_BITS+1:2]. PC bits [1:0] are ignored. PCs differing by 4*2^INDEX_BITS alias to the same entry.
- No flush input; pipeline flush is handled by the consumer discarding pred_* outputs.

Optional Feature:
- Macro GSHARE_EN.
- Defined:
  - Adds a global history register GHR[INDEX_BITS-1:0].
  - ridx=if_pc[INDEX_BITS+1:2]^GHR; widx=upd_pc[INDEX_BITS+1:2]^upd_ghr.
  - On upd_valid, GHR<={GHR[INDEX_BITS-2:0],upd_taken}. History is non-speculative, updated at resolve only.
  - pred_ghr carries the GHR value used for the lookup.
  - When a predict and an update occur in the same cycle, the lookup uses the old GHR.
- Undefined:
  - No GHR storage; pred_ghr is constant 0; upd_ghr is unused.
  - Pure bimodal indexing as above.

Test Plan:
1. Reset, then if_valid=1, if_pc=0x100 -> next cycle pred_valid=1, pred_taken=0. All counters read 0.
2. Two updates, upd_pc=0x100, upd_taken=1 (entry 01->10->11), then predict 0x100 -> pred_taken=1. Third taken update keeps entry at 11; one not-taken update -> 10, still predicts taken.
3. upd_pc=0x104, upd_taken=1, upd_pred_taken=0 -> mispredict=1 for exactly one cycle; branch_cnt=1, mispredict_cnt=1. Matching update -> mispredict=0, branch_cnt=2.
4. Same cycle: predict 0x200 and update 0x200 taken from entry 01 -> pred_taken=0 that cycle. Next predict of 0x200 -> pred_taken=1. Alias 0x300 (INDEX_BITS=6) reads the same entry.
5. Force CNT_WIDTH=4 and issue 20 mispredicting updates -> both statistics counters stop at 15. Assert rst mid-sequence -> all outputs 0 immediately, without waiting for a clk edge.
6. GSHARE_EN defined: updates taken, taken, not-taken -> GHR=6'b000110. Predict 0x100 -> pred_ghr=6'b000110, table index = 0x00^0x06 = 6.
